// File: rtl/mux_word_serializer_pkg.sv
// Shared types and sizing constants for the word serializer and its 64:1 select tree.
package mux_word_serializer_pkg;

  localparam int WIDTH_DEF  = 64;
  localparam int SEL_W_DEF  = 6;
  localparam int MUX_INPUTS = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // The select must address every mux input exactly, with no spare codes.
  function automatic bit sel_w_ok(input int width, input int sel_w);
    return sel_w == $clog2(width);
  endfunction

endpackage

// File: rtl/mux_word_serializer_mux64x1.sv
// 64:1 bit select built as eight 8:1 leaves feeding a final 8:1 stage.
module mux_word_serializer_mux64x1 (
  input  logic [63:0] data_i,
  input  logic [5:0]  sel_i,
  output logic        bit_o
);

  logic [7:0] leaf;

  for (genvar g = 0; g < 8; g++) begin : g_leaf
    logic [7:0] grp;
    assign grp     = data_i[g*8 +: 8];
    assign leaf[g] = grp[sel_i[2:0]];
  end

  assign bit_o = leaf[sel_i[5:3]];

endmodule

// File: rtl/mux_word_serializer.sv
// Loads a parallel word over valid/ready and walks the mux select across bits [len:0],
// presenting one bit per consumer handshake with first/last qualifiers.
//
//  state    | meaning
//  ST_IDLE  | no word held; in_ready high, waiting for a producer word
//  ST_SHIFT | word held; ser_bit valid, select advances on each accepted bit
module mux_word_serializer
  import mux_word_serializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0] in_len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             ser_bit_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             ser_first_o,
  output logic             ser_last_o,
  output logic [SEL_W-1:0] sel_idx_o,
  output logic             busy_o
);

  if (!sel_w_ok(WIDTH, SEL_W) || WIDTH != MUX_INPUTS) begin : g_cfg_err
    $error("mux_word_serializer: WIDTH must be 64 and SEL_W must be clog2(WIDTH)");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [SEL_W-1:0] len_q,   len_d;
  logic [SEL_W-1:0] sel_q,   sel_d;

  logic             shifting;
  logic             at_last;
  logic             beat;
  logic             load;
  logic [SEL_W-1:0] start_idx;
  logic [SEL_W-1:0] end_idx;

  assign start_idx = MSB_FIRST ? len_q : '0;
  assign end_idx   = MSB_FIRST ? '0 : len_q;

  assign shifting = (state_q == ST_SHIFT);
  assign at_last  = shifting & (sel_q == end_idx);
  assign beat     = shifting & ser_ready_i;

  // Ready on the final beat lets the next word load without an idle cycle.
  assign in_ready_o = ~rst_i & (~shifting | (beat & at_last));
  assign load       = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    sel_d   = sel_q;
    if (load) begin
      state_d = ST_SHIFT;
      word_d  = in_data_i;
      len_d   = in_len_i;
      sel_d   = MSB_FIRST ? in_len_i : '0;
    end else if (beat) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - SEL_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
    end
  end

  mux_word_serializer_mux64x1 u_mux (
    .data_i (word_q),
    .sel_i  (sel_q),
    .bit_o  (ser_bit_o)
  );

  assign ser_valid_o = shifting;
  assign busy_o      = shifting;
  assign ser_first_o = shifting & (sel_q == start_idx);
  assign ser_last_o  = at_last;
  assign sel_idx_o   = sel_q;

endmodule
